l2_request_arbiter: RTL



---
 rtl/l2_pkg.sv | 17 +
 rtl/l2_request_arbiter_if.sv | 25 ++
 rtl/l2_request_arbiter_rr_picker.sv | 24 ++
 rtl/l2_request_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// Shared definitions for the L2 request arbiter slice.
//   arb_state_t : arbiter FSM states
//   REQ_I/REQ_D : requester index (also the encoding of last_served)
//   BEAT_W      : width of the per-grant beat counter
package l2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  localparam int REQ_I  = 0;
  localparam int REQ_D  = 1;
  localparam int BEAT_W = 4;

endpackage

// File: rtl/l2_request_arbiter_if.sv
// Generic memory bus between an L1 cache and the L2.
//   addr/wdata/byte_en/ren/wen : request, driven by the requester (cpu side)
//   rdata/busy                 : response, driven by the responder
// Modports:
//   generic_bus : responder view (receives a request)
//   cpu         : requester view (issues a request)
interface generic_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ren;
  logic        wen;
  logic        busy;
  logic [3:0]  byte_en;

  modport generic_bus (
    input  addr, wdata, ren, wen, byte_en,
    output rdata, busy
  );

  modport cpu (
    output addr, wdata, ren, wen, byte_en,
    input  rdata, busy
  );
endinterface

// File: rtl/l2_request_arbiter_rr_picker.sv
// Two-way round-robin picker, purely combinational.
//   req_i         : request vector, bit REQ_I = I-side, bit REQ_D = D-side
//   last_served_i : index of the requester that held the previous grant
//   pick_o        : one-hot winner, 00 when nobody requests
// On a tie the requester that was not served last wins.
module l2_rr_picker
  import l2_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_served_i,
  output logic [1:0] pick_o
);

  always_comb begin
    pick_o = 2'b00;
    unique case (req_i)
      2'b01:   pick_o = 2'b01;
      2'b10:   pick_o = 2'b10;
      2'b11:   pick_o = (last_served_i == 1'(REQ_D)) ? 2'b01 : 2'b10;
      default: pick_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// Arbiter sharing the L2 processor-side bus between the I-side and D-side L1.
// Round-robin grants with a burst lock of LOCK_BEATS completed beats so an L1
// block fill is never interleaved with the other side's traffic.
//   CLK, nRST  : clock, synchronous active-low reset
//   icache_if  : I-side requester (responder modport)
//   dcache_if  : D-side requester (responder modport)
//   l2_if      : downstream bus to l2_cache (requester modport)
//   grant      : one-hot owner, bit0 = I, bit1 = D, 00 = none
//   beat_cnt   : completed beats in the current grant
module l2_request_arbiter
  import l2_pkg::*;
#(
  parameter int LOCK_BEATS     = 4,
  parameter int FIRST_PRIORITY = 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  generic_bus_if.generic_bus     icache_if,
  generic_bus_if.generic_bus     dcache_if,
  generic_bus_if.cpu             l2_if,
  output logic [1:0]             grant,
  output logic [BEAT_W-1:0]      beat_cnt
);

  if (LOCK_BEATS < 1 || LOCK_BEATS > 16) begin : g_bad_lock
    $error("l2_request_arbiter: LOCK_BEATS must be in 1..16");
  end
  if (FIRST_PRIORITY != REQ_I && FIRST_PRIORITY != REQ_D) begin : g_bad_prio
    $error("l2_request_arbiter: FIRST_PRIORITY must be 0 or 1");
  end

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LOCK_BEATS - 1);
  // Reset as if the non-preferred side was served last, so the first tie
  // goes to FIRST_PRIORITY.
  localparam logic LAST_RST = (FIRST_PRIORITY == REQ_D) ? 1'(REQ_I) : 1'(REQ_D);

  arb_state_t        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              last_q, last_d;

  logic [1:0] req;
  logic [1:0] pick;
  logic       owner_req;
  logic       owner_id;

  assign req[REQ_I] = icache_if.ren | icache_if.wen;
  assign req[REQ_D] = dcache_if.ren | dcache_if.wen;

  l2_rr_picker u_picker (
    .req_i         (req),
    .last_served_i (last_q),
    .pick_o        (pick)
  );

  always_comb begin
    owner_id  = (state_q == GRANT_D) ? 1'(REQ_D) : 1'(REQ_I);
    owner_req = req[owner_id];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick[REQ_I]) begin
          state_d = GRANT_I;
          grant_d = 2'b01;
        end else if (pick[REQ_D]) begin
          state_d = GRANT_D;
          grant_d = 2'b10;
        end
      end
      GRANT_I, GRANT_D: begin
        // A release (final beat or dropped request) always passes through
        // IDLE, which is what gives the other side its turn.
        if (owner_req && !l2_if.busy) begin
          if (beat_q >= LAST_BEAT) begin
            state_d = IDLE;
            grant_d = 2'b00;
            beat_d  = '0;
            last_d  = owner_id;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else if (!owner_req) begin
          state_d = IDLE;
          grant_d = 2'b00;
          beat_d  = '0;
          last_d  = owner_id;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      beat_q  <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
    end
  end

  // Bus steering follows the registered grant, so the downstream request
  // appears the cycle after the arbitration edge and drops right after reset.
  always_comb begin
    l2_if.addr        = '0;
    l2_if.wdata       = '0;
    l2_if.ren         = 1'b0;
    l2_if.wen         = 1'b0;
    l2_if.byte_en     = '0;
    icache_if.busy    = 1'b1;
    icache_if.rdata   = '0;
    dcache_if.busy    = 1'b1;
    dcache_if.rdata   = '0;
    if (grant_q[REQ_I]) begin
      l2_if.addr      = icache_if.addr;
      l2_if.wdata     = icache_if.wdata;
      l2_if.ren       = icache_if.ren;
      l2_if.wen       = icache_if.wen;
      l2_if.byte_en   = icache_if.byte_en;
      icache_if.busy  = l2_if.busy;
      icache_if.rdata = l2_if.rdata;
    end else if (grant_q[REQ_D]) begin
      l2_if.addr      = dcache_if.addr;
      l2_if.wdata     = dcache_if.wdata;
      l2_if.ren       = dcache_if.ren;
      l2_if.wen       = dcache_if.wen;
      l2_if.byte_en   = dcache_if.byte_en;
      dcache_if.busy  = l2_if.busy;
      dcache_if.rdata = l2_if.rdata;
    end
  end

  assign grant    = grant_q;
  assign beat_cnt = beat_q;

endmodule
